// File: rtl/ecu_pkg.sv
// ecu_pkg: shared definitions for the ECU traffic endpoint.
//   - Tx FSM state encoding
//   - flit field offsets.  A flit is {tail, payload, dest_y, dest_x}, with dest_x at the LSBs.
//   - clog2 helper, which never returns less than 1
package ecu_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  function automatic int clog2i(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int dx_lsb();
    return 0;
  endfunction

  function automatic int dy_lsb(input int x_w);
    return x_w;
  endfunction

  function automatic int pl_lsb(input int x_w, input int y_w);
    return x_w + y_w;
  endfunction

  function automatic int tail_bit(input int x_w, input int y_w, input int dw);
    return x_w + y_w + dw;
  endfunction

endpackage

// File: rtl/ecu_rr_arbiter.sv
// ecu_rr_arbiter: combinational round-robin pick.
//   req     : one pending bit per message entry
//   ptr     : first index to consider; the search wraps around
//   gnt_idx : selected entry (0 when there is no request)
//   gnt_any : at least one request is present
module ecu_rr_arbiter
  import ecu_pkg::*;
#(
  parameter int NUM_MSG = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_MSG-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  always_comb begin
    logic [IDX_W-1:0] idx_v;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx_v   = '0;
    for (int i = 0; i < NUM_MSG; i++) begin
      idx_v = IDX_W'((int'(ptr) + i) % NUM_MSG);
      if (!gnt_any && req[idx_v]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_v;
      end
    end
  end

endmodule

// File: rtl/ecu_traffic_gen.sv
// ecu_traffic_gen: a programmable, periodic CAN-over-NoC traffic source and sink.
//   cfg_*           : message table write port (one entry per cycle)
//   o_data/o_valid  : Tx flit to the router; held stable until i_ready
//   i_data/i_valid  : Rx flit from the router; the sink always accepts
//   rx_count, rx_last_payload, rx_err : Rx statistics
//   ovr_count       : periods lost because the entry was still pending
module ecu_traffic_gen
  import ecu_pkg::*;
#(
  parameter int XCORD      = 0,
  parameter int YCORD      = 0,
  parameter int X_W        = 1,
  parameter int Y_W        = 1,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_MSG    = 4,
  parameter int PER_W      = 16,
  parameter int CNT_W      = 16,
  localparam int FLIT_W    = X_W + Y_W + DATA_WIDTH + 1,
  localparam int IDX_W     = clog2i(NUM_MSG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_addr,
  input  logic                  cfg_en,
  input  logic [X_W-1:0]        cfg_dest_x,
  input  logic [Y_W-1:0]        cfg_dest_y,
  input  logic [DATA_WIDTH-1:0] cfg_payload,
  input  logic [PER_W-1:0]      cfg_period,
  output logic [FLIT_W-1:0]     o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  input  logic [FLIT_W-1:0]     i_data,
  input  logic                  i_valid,
  output logic [CNT_W-1:0]      rx_count,
  output logic [DATA_WIDTH-1:0] rx_last_payload,
  output logic                  rx_err,
  output logic [CNT_W-1:0]      ovr_count
);

  localparam int DX_LSB   = dx_lsb();
  localparam int DY_LSB   = dy_lsb(X_W);
  localparam int PL_LSB   = pl_lsb(X_W, Y_W);
  localparam int TAIL_BIT = tail_bit(X_W, Y_W, DATA_WIDTH);

  // message table and per-entry scheduling state
  logic [NUM_MSG-1:0]                 en_q, en_d, pend_q, pend_d;
  logic [NUM_MSG-1:0][X_W-1:0]        dx_q, dx_d;
  logic [NUM_MSG-1:0][Y_W-1:0]        dy_q, dy_d;
  logic [NUM_MSG-1:0][DATA_WIDTH-1:0] pl_q, pl_d;
  logic [NUM_MSG-1:0][PER_W-1:0]      per_q, per_d, cnt_q, cnt_d;
  logic [IDX_W-1:0]                   rr_q, rr_d;
  state_e                             state_q, state_d;
  logic [FLIT_W-1:0]                  o_data_q, o_data_d;
  logic                               o_valid_q, o_valid_d;
  logic [CNT_W-1:0]                   rx_count_q, rx_count_d, ovr_q, ovr_d;
  logic [DATA_WIDTH-1:0]              rx_pl_q, rx_pl_d;
  logic                               rx_err_q, rx_err_d;

  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

  // the tail bit of incoming flits carries no information for the sink
  logic unused_tail;
  assign unused_tail = i_data[TAIL_BIT];

  ecu_rr_arbiter #(.NUM_MSG(NUM_MSG), .IDX_W(IDX_W)) u_arb (
    .req     (pend_q),
    .ptr     (rr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    logic [NUM_MSG-1:0] clr;
    logic [FLIT_W-1:0]  flit_v;
    logic [CNT_W:0]     ovr_sum;
    int                 ovr_n;
    en_d = en_q;  pend_d = pend_q;  dx_d = dx_q;  dy_d = dy_q;
    pl_d = pl_q;  per_d = per_q;    cnt_d = cnt_q;
    rr_d = rr_q;  state_d = state_q;
    o_data_d = o_data_q;  o_valid_d = o_valid_q;
    rx_count_d = rx_count_q;  rx_pl_d = rx_pl_q;  rx_err_d = rx_err_q;
    clr = '0;  ovr_n = 0;  flit_v = '0;

    flit_v[DX_LSB +: X_W]        = dx_q[gnt_idx];
    flit_v[DY_LSB +: Y_W]        = dy_q[gnt_idx];
    flit_v[PL_LSB +: DATA_WIDTH] = pl_q[gnt_idx];
    flit_v[TAIL_BIT]             = 1'b1;

    case (state_q)
      IDLE: if (gnt_any) begin
        o_data_d     = flit_v;
        o_valid_d    = 1'b1;
        clr[gnt_idx] = 1'b1;
        rr_d         = (gnt_idx == IDX_W'(NUM_MSG - 1)) ? '0 : gnt_idx + 1'b1;
        state_d      = SEND;
      end
      SEND: if (o_valid_q && i_ready) begin
        o_valid_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < NUM_MSG; i++) begin
      if (en_q[i]) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i] = per_q[i];
          // a fire that coincides with this entry's grant is a fresh period, not an overrun
          if (pend_q[i] && !clr[i]) ovr_n++;
          pend_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
          if (clr[i]) pend_d[i] = 1'b0;
        end
      end else if (clr[i]) begin
        pend_d[i] = 1'b0;
      end
      // a table write overrides the scheduling update; o_data is a separate copy and is unaffected
      if (cfg_we && cfg_addr == IDX_W'(i)) begin
        en_d[i]   = cfg_en;
        dx_d[i]   = cfg_dest_x;
        dy_d[i]   = cfg_dest_y;
        pl_d[i]   = cfg_payload;
        per_d[i]  = cfg_period;
        cnt_d[i]  = cfg_period;
        pend_d[i] = 1'b0;
      end
    end

    ovr_sum = {1'b0, ovr_q} + (CNT_W + 1)'(ovr_n);
    ovr_d   = ovr_sum[CNT_W] ? '1 : ovr_sum[CNT_W-1:0];

    if (i_valid) begin
      rx_count_d = rx_count_q + 1'b1;
      rx_pl_d    = i_data[PL_LSB +: DATA_WIDTH];
      if (i_data[DX_LSB +: X_W] != X_W'(XCORD) || i_data[DY_LSB +: Y_W] != Y_W'(YCORD))
        rx_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;  pend_q <= '0;  dx_q <= '0;  dy_q <= '0;
      pl_q <= '0;  per_q <= '0;   cnt_q <= '0;
      rr_q <= '0;  state_q <= IDLE;
      o_data_q <= '0;  o_valid_q <= 1'b0;
      rx_count_q <= '0;  rx_pl_q <= '0;  rx_err_q <= 1'b0;  ovr_q <= '0;
    end else begin
      en_q <= en_d;  pend_q <= pend_d;  dx_q <= dx_d;  dy_q <= dy_d;
      pl_q <= pl_d;  per_q <= per_d;    cnt_q <= cnt_d;
      rr_q <= rr_d;  state_q <= state_d;
      o_data_q <= o_data_d;  o_valid_q <= o_valid_d;
      rx_count_q <= rx_count_d;  rx_pl_q <= rx_pl_d;  rx_err_q <= rx_err_d;  ovr_q <= ovr_d;
    end
  end

  assign o_data          = o_data_q;
  assign o_valid         = o_valid_q;
  assign rx_count        = rx_count_q;
  assign rx_last_payload = rx_pl_q;
  assign rx_err          = rx_err_q;
  assign ovr_count       = ovr_q;

endmodule

// File: tb/tb_ecu_traffic_gen.sv
module tb_ecu_traffic_gen;
  localparam int NM = 3;
  localparam int DW = 128;
  localparam int FW = 131;
  localparam logic [127:0] PL0 = 128'hcb0000000eafac43_800000004b200000;

  logic           clk = 1'b0, rst = 1'b1;
  logic           cfg_we = 1'b0, cfg_en = 1'b0;
  logic [1:0]     cfg_addr = '0;
  logic [0:0]     cfg_dest_x = '0, cfg_dest_y = '0;
  logic [DW-1:0]  cfg_payload = '0;
  logic [15:0]    cfg_period = '0;
  logic [FW-1:0]  o_data, i_data = '0;
  logic           o_valid, i_ready = 1'b0, i_valid = 1'b0;
  logic [15:0]    rx_count, ovr_count;
  logic [DW-1:0]  rx_last_payload;
  logic           rx_err;

  int checks = 0, errors = 0;

  ecu_traffic_gen #(.NUM_MSG(NM)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .cfg_dest_x(cfg_dest_x), .cfg_dest_y(cfg_dest_y), .cfg_payload(cfg_payload),
    .cfg_period(cfg_period), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .i_data(i_data), .i_valid(i_valid), .rx_count(rx_count),
    .rx_last_payload(rx_last_payload), .rx_err(rx_err), .ovr_count(ovr_count));

  always #5 clk = ~clk;

  // reference model: absolute fire times, a pending flag per message, one busy Tx slot
  bit            m_en[NM], m_pend[NM], m_busy, m_rxerr;
  logic [0:0]    m_dx[NM], m_dy[NM];
  logic [DW-1:0] m_pl[NM], m_rxpl;
  int            m_per[NM], m_rr, m_ovr, m_rxc;
  longint        m_next[NM], m_cyc = 0;
  logic [FW-1:0] m_flit;

  task automatic model_step();
    bit fire[NM];
    int g;
    if (rst) begin
      for (int i = 0; i < NM; i++) begin
        m_en[i] = 0; m_pend[i] = 0; m_dx[i] = '0; m_dy[i] = '0; m_pl[i] = '0; m_per[i] = 0; m_next[i] = 0;
      end
      m_busy = 0; m_rr = 0; m_ovr = 0; m_rxc = 0; m_rxpl = '0; m_rxerr = 0; m_flit = '0;
      m_cyc++;
      return;
    end
    for (int i = 0; i < NM; i++) begin
      fire[i] = m_en[i] && (m_next[i] == m_cyc);
      if (fire[i]) m_next[i] = m_cyc + m_per[i] + 1;
    end
    g = -1;
    if (!m_busy)
      for (int k = 0; k < NM; k++)
        if (g < 0 && m_pend[(m_rr + k) % NM]) g = (m_rr + k) % NM;
    if (m_busy && i_ready) m_busy = 0;
    if (g >= 0) begin
      m_busy = 1;
      m_flit = {1'b1, m_pl[g], m_dy[g], m_dx[g]};
      m_rr = (g + 1) % NM;
    end
    for (int i = 0; i < NM; i++) begin
      if (fire[i]) begin
        if (m_pend[i] && i != g && m_ovr < 65535) m_ovr++;
        m_pend[i] = 1;
      end else if (i == g) m_pend[i] = 0;
    end
    if (cfg_we && cfg_addr < NM) begin
      m_en[cfg_addr] = cfg_en; m_dx[cfg_addr] = cfg_dest_x; m_dy[cfg_addr] = cfg_dest_y;
      m_pl[cfg_addr] = cfg_payload; m_per[cfg_addr] = cfg_period;
      m_next[cfg_addr] = m_cyc + cfg_period + 1; m_pend[cfg_addr] = 0;
    end
    if (i_valid) begin
      m_rxc = (m_rxc + 1) % 65536;
      m_rxpl = i_data[129:2];
      if (i_data[0] != 1'b0 || i_data[1] != 1'b0) m_rxerr = 1;
    end
    m_cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_we = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input bit en, input logic [0:0] dx, input logic [0:0] dy,
                           input logic [DW-1:0] pl, input int per);
    cfg_we = 1'b1; cfg_addr = a; cfg_en = en; cfg_dest_x = dx; cfg_dest_y = dy;
    cfg_payload = pl; cfg_period = 16'(per);
    tick();
    cfg_we = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_pl();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || rx_count !== '0 || ovr_count !== '0 || rx_err !== 1'b0 ||
        rx_last_payload !== '0) begin
      errors++;
      $display("FAIL reset_state: o_valid=%b o_data=%h rx_count=%0d ovr=%0d rx_err=%b want all 0",
               o_valid, o_data, rx_count, ovr_count, rx_err);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_periodic();
    int rises[$];
    logic [FW-1:0] f;
    bit prev;
    do_reset();
    i_ready = 1'b1;
    cfg_write(2'd0, 1, 1'b1, 1'b0, PL0, 3);
    prev = 0; f = '0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      checks++;
      if (o_valid !== m_busy || (m_busy && o_data !== m_flit) || ovr_count !== 16'(m_ovr)) begin
        errors++;
        $display("FAIL periodic_model cyc%0d: o_valid=%b o_data=%h ovr=%0d want %b %h %0d",
                 n, o_valid, o_data, ovr_count, m_busy, m_flit, m_ovr);
      end
      if (o_valid && !prev) begin
        rises.push_back(n);
        if (rises.size() == 1) f = o_data;
      end
      prev = o_valid;
    end
    checks++;
    if (rises.size() < 2 || rises[0] != 5 || rises[1] != 9) begin
      errors++;
      $display("FAIL periodic_timing: rises=%p want first 5 then 9", rises);
    end
    checks++;
    if (f[0] !== 1'b1 || f[1] !== 1'b0 || f[129:2] !== PL0 || f[130] !== 1'b1) begin
      errors++;
      $display("FAIL periodic_fields: flit=%h want dx=1 dy=0 payload=%h tail=1", f, PL0);
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] held;
    int n;
    do_reset();
    i_ready = 1'b1;
    cfg_write(2'd0, 1, 1'b1, 1'b0, PL0, 3);
    n = 0;
    while (!o_valid && n < 20) begin tick(); n++; end
    checks++;
    if (!o_valid) begin errors++; $display("FAIL bp_wait_valid: o_valid=%b want 1 within 20 cycles", o_valid); end
    i_ready = 1'b0;
    held = o_data;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== held) begin
        errors++;
        $display("FAIL bp_hold k%0d: o_valid=%b o_data=%h want 1 %h", k, o_valid, o_data, held);
      end
    end
    i_ready = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0 || ovr_count !== 16'd1 || ovr_count !== 16'(m_ovr)) begin
      errors++;
      $display("FAIL bp_transfer: o_valid=%b ovr=%0d want 0 and 1", o_valid, ovr_count);
    end
  endtask

  task automatic test_rr();
    logic [DW-1:0] pls[NM];
    int exp_idx, got, seen, prev_ovr;
    bit prev;
    do_reset();
    i_ready = 1'b1;
    for (int i = 0; i < NM; i++) pls[i] = rnd_pl();
    for (int i = 0; i < NM; i++) cfg_write(2'(i), 1, 1'b0, 1'b1, pls[i], 0);
    exp_idx = -1; seen = 0; prev = o_valid; prev_ovr = ovr_count;
    for (int n = 0; n < 24; n++) begin
      tick();
      checks++;
      if (o_valid !== m_busy || (m_busy && o_data !== m_flit) || ovr_count !== 16'(m_ovr)) begin
        errors++;
        $display("FAIL rr_model n%0d: o_valid=%b o_data=%h ovr=%0d want %b %h %0d",
                 n, o_valid, o_data, ovr_count, m_busy, m_flit, m_ovr);
      end
      checks++;
      if (int'(ovr_count) <= prev_ovr) begin
        errors++;
        $display("FAIL rr_ovr_inc n%0d: ovr=%0d want > %0d", n, ovr_count, prev_ovr);
      end
      prev_ovr = ovr_count;
      if (o_valid && !prev) begin
        got = -1;
        for (int i = 0; i < NM; i++) if (o_data[129:2] === pls[i]) got = i;
        if (exp_idx >= 0) begin
          checks++;
          if (got != exp_idx) begin
            errors++;
            $display("FAIL rr_order n%0d: grant=%0d want %0d", n, got, exp_idx);
          end
        end
        if (got >= 0) seen++;
        exp_idx = (got + 1) % NM;
      end
      prev = o_valid;
    end
    checks++;
    if (seen < 5) begin errors++; $display("FAIL rr_grants: grants=%0d want >= 5", seen); end
  endtask

  task automatic test_rx();
    logic [DW-1:0] p;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      p = rnd_pl();
      i_valid = 1'b1;
      i_data = {1'b1, p, 1'b0, (k == 3) ? 1'b1 : 1'b0};
      tick();
      i_valid = 1'b0;
      checks++;
      if (rx_count !== 16'(k + 1) || rx_last_payload !== p || rx_err !== (k == 3)) begin
        errors++;
        $display("FAIL rx_flit%0d: count=%0d payload=%h err=%b want %0d %h %b",
                 k, rx_count, rx_last_payload, rx_err, k + 1, p, k == 3);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    i_ready = 1'b0;
    cfg_write(2'd0, 1, 1'b1, 1'b1, rnd_pl(), 1);
    i_valid = 1'b1; i_data = {1'b1, rnd_pl(), 2'b00};
    tick();
    i_valid = 1'b0;
    for (int n = 0; n < 30 && ovr_count == 0; n++) tick();
    checks++;
    if (ovr_count == 0 || o_valid !== 1'b1 || rx_count == 0) begin
      errors++;
      $display("FAIL midrst_setup: ovr=%0d o_valid=%b rx=%0d want nonzero, 1, nonzero", ovr_count, o_valid, rx_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || rx_count !== '0 || ovr_count !== '0) begin
      errors++;
      $display("FAIL midrst_async: o_valid=%b rx=%0d ovr=%0d want 0 0 0", o_valid, rx_count, ovr_count);
    end
    tick();
    rst = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 15; n++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_quiet n%0d: o_valid=%b want 0", n, o_valid); end
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    i_ready = 1'b1;
    cfg_write(2'd3, 1, 1'b0, 1'b0, rnd_pl(), 0);
    cfg_write(2'd1, 0, 1'b0, 1'b0, rnd_pl(), 0);
    for (int n = 0; n < 20; n++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0 || ovr_count !== '0) begin
        errors++;
        $display("FAIL bad_addr n%0d: o_valid=%b ovr=%0d want 0 0", n, o_valid, ovr_count);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_en = ($urandom_range(0, 3) != 0);
      cfg_dest_x = 1'($urandom); cfg_dest_y = 1'($urandom);
      cfg_payload = rnd_pl();
      cfg_period = 16'($urandom_range(0, 6));
      i_ready = ($urandom_range(0, 9) < 7);
      i_valid = ($urandom_range(0, 9) < 3);
      i_data = {1'b1, rnd_pl(), 2'($urandom)};
      tick();
      checks++;
      if (o_valid !== m_busy || (m_busy && o_data !== m_flit) || ovr_count !== 16'(m_ovr) ||
          rx_count !== 16'(m_rxc) || rx_last_payload !== m_rxpl || rx_err !== m_rxerr) begin
        errors++;
        $display("FAIL random n%0d: v=%b d=%h ovr=%0d rx=%0d err=%b want %b %h %0d %0d %b",
                 n, o_valid, o_data, ovr_count, rx_count, rx_err, m_busy, m_flit, m_ovr, m_rxc, m_rxerr);
      end
    end
    cfg_we = 1'b0; i_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_backpressure();
    test_rr();
    test_rx();
    test_reset_mid_send();
    test_bad_addr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecu_traffic_gen.md
Name: ecu_traffic_gen

Overview:
- Synthesizable, parametrised ECU endpoint for the CAN-over-NoC mesh.
- Holds a small table of periodic messages, schedules them with round-robin arbitration, and injects one flit per message into the local router port with backpressure.
- Also sinks flits from the router: counts them, captures the last payload, and flags any flit delivered to the wrong node.
- Replaces fixed single-shot ECU stimulus with a programmable, multi-message traffic source/sink usable in both benches and synthesis.

Parameters:
- XCORD, 0, x coordinate of this node.
- YCORD, 0, y coordinate of this node.
- X_W, 1, width of the x destination field.
- Y_W, 1, width of the y destination field.
- DATA_WIDTH, 128, payload width.
- NUM_MSG, 4, number of message table entries (≥1).
- PER_W, 16, width of the period field.
- CNT_W, 16, width of the rx and overrun counters.
- Derived: FLIT_W = X_W+Y_W+DATA_WIDTH+1 (131 at defaults); IDX_W = max(1,clog2(NUM_MSG)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  IDX_W  entry index.
- cfg_en  in  1  entry enable.
- cfg_dest_x  in  X_W  destination x.
- cfg_dest_y  in  Y_W  destination y.
- cfg_payload  in  DATA_WIDTH  payload.
- cfg_period  in  PER_W  period P (interval P+1 cycles).
- o_data  out  FLIT_W  {tail=1, payload, dest_y, dest_x}; dest_x at LSBs.
- o_valid  out  1  flit valid.
- i_ready  in  1  router accepts o_data this cycle.
- i_data  in  FLIT_W  incoming flit, same format.
- i_valid  in  1  incoming flit valid.
- rx_count  out  CNT_W  flits received.
- rx_last_payload  out  DATA_WIDTH  payload of the last received flit.
- rx_err  out  1  sticky: a flit arrived whose destination is not (XCORD,YCORD).
- ovr_count  out  CNT_W  periods lost while the entry was still pending.

Behaviour:
- Reset (async, rst=1): all outputs 0; table entries disabled with all fields 0; pending bits 0; period counters 0; RR pointer 0; FSM=IDLE. Counters, o_valid and pending are forced to 0 immediately on rst assertion, including mid-send.
- Table write (cfg_we=1, cfg_addr<NUM_MSG): entry fields written; entry period counter loaded with cfg_period; entry pending cleared. cfg_addr ≥ NUM_MSG is ignored.
- A write to an entry currently latched in o_data does not alter o_data.
- Period counter, per enabled entry, each cycle:
  - if counter == 0: set pending and reload P;
  - otherwise decrement.
  - First flit is pending P+1 cycles after the write; interval is P+1 cycles; P=0 fires every cycle.
  - Disabled entries hold the counter and never set pending.
- Overrun: if an entry fires while its pending bit is already set, pending stays 1 and ovr_count increments. ovr_count saturates at all-ones.
- FSM IDLE:
  - if any pending: select the lowest index ≥ RR pointer (wrapping), load o_data from that entry, set o_valid=1, clear its pending bit, set RR pointer to index+1 mod NUM_MSG, go SEND.
  - A fire and a clear of the same entry in the same cycle leaves pending=1, with no overrun.
- FSM SEND:
  - o_data and o_valid are held stable until i_ready=1.
  - On a cycle with o_valid & i_ready: transfer occurs, o_valid=0 next cycle, go IDLE.
  - Throughput is at most one flit per 2 cycles. Latency from pending set to o_valid is 1 cycle when IDLE.
- Rx, on i_valid=1 (i_ready not consulted; the sink always accepts):
  - rx_count += 1, wrapping;
  - rx_last_payload <= payload field;
  - if dest_x != XCORD or dest_y != YCORD: rx_err <= 1 (sticky until reset).
  - Rx is independent of the Tx FSM; simultaneous rx and tx are both handled.

Decomposition:
- Shared package ecu_pkg holds:
  - flit field offsets (DX_LSB, DY_LSB, PL_LSB, TAIL_BIT) as functions of X_W, Y_W, DATA_WIDTH;
  - FSM state encoding IDLE=0 / SEND=1;
  - the clog2 helper.
- One sub-module, ecu_rr_arbiter: NUM_MSG-wide request vector plus pointer in, grant index and any-grant flag out; combinational.

Test Plan:
- Write entry 0 (en=1, dest (1,0), payload 128'hcb0000000eafac43_800000004b200000, P=3), i_ready=1.
  - Required: first o_valid 5 cycles after the write cycle, then every 4 cycles.
  - o_data[0]=1, o_data[1]=0, o_data[129:2]=payload, o_data[130]=1.
- Same setup, i_ready=0 for 6 cycles after o_valid rises.
  - Required: o_data/o_valid stable throughout; one transfer when i_ready rises; ovr_count=1.
- Entries 0, 1, 2 with P=0, i_ready=1.
  - Required: grants in order 0,1,2,0,…; each flit carries its own payload; ovr_count increments each cycle.
- Inject 3 flits with dest (XCORD,YCORD), then 1 flit with dest x≠XCORD.
  - Required: rx_count=4; rx_last_payload=last payload; rx_err=1 after the 4th flit, rx_err=0 before it.
- Assert rst for 1 cycle while in SEND with i_ready=0.
  - Required: o_valid=0 immediately; rx_count=0 and ovr_count=0; no flit emitted until the table is rewritten.
- cfg_addr=NUM_MSG write, then a disabled entry with P=0.
  - Required: no o_valid ever asserted; ovr_count=0.
